// File: rtl/msk_and_hpc3_stream.sv
// msk_and_hpc3_stream: W-lane, d-share masked AND (HPC3) with valid/ready handshakes on data and randomness.
// Latency: 1 cycle (accept at edge n -> o_out_valid in cycle n+1); throughput 1 transaction/cycle.
// Backpressure: single register stage holds while o_out_valid & ~i_out_ready; o_in_ready = ~o_out_valid | i_out_ready.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_ina, i_inb  [W*d]       input sharings, share i of lane k at bit i*W+k
//   i_in_valid / o_in_ready   data handshake
//   i_rnd [W*d*(d-1)]         randomness, lane k slice [k*d(d-1) +: d(d-1)], low half r, high half r'
//   i_rnd_valid / o_rnd_ready randomness handshake, consumed only when data is accepted
//   o_out [W*d]               output sharing of a*b, same layout
//   o_out_valid / i_out_ready output handshake
// Optional macro: MSKAND_HPC3_CROSS_EN drops the inner-domain products (output recombines to cross terms only).
module msk_and_hpc3_stream #(
  parameter int d = 2,
  parameter int W = 8,
  localparam int RW = W * d * (d - 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [W*d-1:0]  i_ina,
  input  logic [W*d-1:0]  i_inb,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [RW-1:0]   i_rnd,
  input  logic            i_rnd_valid,
  output logic            o_rnd_ready,
  output logic [W*d-1:0]  o_out,
  output logic            o_out_valid,
  input  logic            i_out_ready
);

  localparam int NP = d * (d - 1) / 2;  // pairs per lane = size of one random half
  localparam int LW = d * (d - 1);      // random bits per lane

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // U/V kept as full d x d matrices; the diagonal is always loaded with zero so it
  // drops out of the output XOR reduction without special-casing.
  logic [d-1:0][d-1:0] r_u [W];
  logic [d-1:0][d-1:0] r_v [W];
  logic [d-1:0]        r_a [W];
  logic [d-1:0][d-1:0] w_u [W];
  logic [d-1:0][d-1:0] w_v [W];
  logic [d-1:0]        w_a [W];
`ifndef MSKAND_HPC3_CROSS_EN
  logic [d-1:0]        r_p [W];
  logic [d-1:0]        w_p [W];
`endif

  logic w_acc;

  assign o_in_ready  = ~o_out_valid | i_out_ready;
  // Randomness is only requested when data is present, so no rnd is burned on empty cycles.
  assign o_rnd_ready = i_in_valid & o_in_ready;
  assign w_acc       = o_rnd_ready & i_rnd_valid;

  // Upper-triangle packing of the symmetric r/r' matrices, valid for i < j.
  function automatic int f_idx(input int i, input int j);
    return i * d - (i * (i + 1)) / 2 + (j - 1 - i);
  endfunction

  // Next-stage values, one independent cone per (lane, share pair).
  always_comb begin : next_regs
    for (int k = 0; k < W; k++) begin
      w_u[k] = '0;
      w_v[k] = '0;
      w_a[k] = '0;
`ifndef MSKAND_HPC3_CROSS_EN
      w_p[k] = '0;
`endif
      for (int i = 0; i < d; i++) begin
        w_a[k][i] = i_ina[i*W+k];
`ifndef MSKAND_HPC3_CROSS_EN
        w_p[k][i] = i_ina[i*W+k] & i_inb[i*W+k];
`endif
        for (int j = 0; j < d; j++) begin
          if (i != j) begin
            w_u[k][i][j] = (~i_ina[i*W+k] & i_rnd[k*LW + f_idx((i < j) ? i : j, (i < j) ? j : i)])
                         ^ i_rnd[k*LW + NP + f_idx((i < j) ? i : j, (i < j) ? j : i)];
            w_v[k][i][j] = i_inb[j*W+k] ^ i_rnd[k*LW + f_idx((i < j) ? i : j, (i < j) ? j : i)];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < W; k++) begin
        r_u[k] <= '0;
        r_v[k] <= '0;
        r_a[k] <= '0;
`ifndef MSKAND_HPC3_CROSS_EN
        r_p[k] <= '0;
`endif
      end
    end else if (w_acc) begin
      r_u <= w_u;
      r_v <= w_v;
      r_a <= w_a;
`ifndef MSKAND_HPC3_CROSS_EN
      r_p <= w_p;
`endif
    end
  end

  // out_valid FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // out_valid FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_acc) w_state_nxt = S_FULL;
      S_FULL:  if (i_out_ready && !w_acc) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // out_valid FSM: outputs
  always_comb begin
    o_out_valid = (r_state == S_FULL);
  end

  // Output recombination: out_i = P_i ^ XOR_j (U_ij ^ A_i & V_ij), purely from registers.
  always_comb begin
    o_out = '0;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < d; i++) begin
`ifndef MSKAND_HPC3_CROSS_EN
        o_out[i*W+k] = r_p[k][i] ^ (^(r_u[k][i] ^ (r_v[k][i] & {d{r_a[k][i]}})));
`else
        o_out[i*W+k] = ^(r_u[k][i] ^ (r_v[k][i] & {d{r_a[k][i]}}));
`endif
      end
    end
  end

endmodule

// File: tb/tb_msk_and_hpc3_stream.sv
// tb_msk_and_hpc3_stream: scoreboard bench for the streaming masked AND (d=3, W=8).
// Stimulus pushes the recombined expectation on every accept; a monitor pops on every output beat.
// Randomized handshakes plus directed back-pressure, starvation and reset sequences.
module tb_msk_and_hpc3_stream;

  localparam int D  = 3;
  localparam int W  = 8;
  localparam int RW = W * D * (D - 1);
  localparam int N_RANDOM = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic [W*D-1:0]  ina;
  logic [W*D-1:0]  inb;
  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   rnd;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [W*D-1:0]  out;
  logic            out_valid;
  logic            out_ready;

  always #5 clk = ~clk;

  msk_and_hpc3_stream #(.d(D), .W(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ina       (ina),
    .i_inb       (inb),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_rnd       (rnd),
    .i_rnd_valid (rnd_valid),
    .o_rnd_ready (rnd_ready),
    .o_out       (out),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fires    = 0;
  int accepts  = 0;
  bit hold_data = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // XOR of all shares gives the plain value per lane.
  function automatic logic [W-1:0] recomb(input logic [W*D-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r ^= s[i*W +: W];
    return r;
  endfunction

  // Reference: a&b on recombined values; cross mode removes the same-share products.
  function automatic logic [W-1:0] model(input logic [W*D-1:0] a_sh, input logic [W*D-1:0] b_sh);
    logic [W-1:0] e;
    e = recomb(a_sh) & recomb(b_sh);
`ifdef MSKAND_HPC3_CROSS_EN
    for (int i = 0; i < D; i++) e ^= a_sh[i*W +: W] & b_sh[i*W +: W];
`endif
    return e;
  endfunction

  // One clock of stimulus: drive after the edge, decide acceptance at the falling edge.
  task automatic cycle(input bit iv, input bit rv, input bit ordy);
    logic [31:0] t32a;
    logic [31:0] t32b;
    logic [63:0] t64;
    @(posedge clk);
    #1;
    if (!hold_data) begin
      t32a = $urandom;
      t32b = $urandom;
      ina  = t32a[W*D-1:0];
      inb  = t32b[W*D-1:0];
    end
    t64       = {$urandom, $urandom};
    rnd       = t64[RW-1:0];
    in_valid  = iv;
    rnd_valid = rv;
    out_ready = ordy;
    @(negedge clk);
    if (in_valid && rnd_valid && in_ready) begin
      exp_q.push_back(model(ina, inb));
      accepts++;
      hold_data = 1'b0;
    end else begin
      // Upstream keeps presented data stable until it is accepted.
      hold_data = in_valid;
    end
  endtask

  // Monitor: compares every output beat and checks the output is frozen while stalled.
  logic [W*D-1:0] held_out;
  bit             held_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) check("stall_hold", 64'(out), 64'(held_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(1), 64'(0));
        else check("out_data", 64'(recomb(out)), 64'(exp_q.pop_front()));
      end
      held_v   = out_valid && !out_ready;
      held_out = out;
      if (rnd_valid && rnd_ready) fires++;
    end
  end

  initial begin
    int guard;
    rst       = 1'b1;
    ina       = '0;
    inb       = '0;
    rnd       = '0;
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out",       64'(out),       64'(0));
    check("reset_in_ready",  64'(in_ready),  64'(1));
    check("reset_rnd_ready", 64'(rnd_ready), 64'(0));

    // Directed vector: a = AA, b = 66 across three shares.
    ina = {8'h00, 8'hFF, 8'h55};
    inb = {8'h00, 8'h55, 8'h33};
    hold_data = 1'b1;
    cycle(1, 1, 1);
    cycle(0, 0, 1);
    check("vec_out_valid", 64'(out_valid), 64'(1));
`ifdef MSKAND_HPC3_CROSS_EN
    check("vec_recomb", 64'(recomb(out)), 64'(8'h66));
`else
    check("vec_recomb", 64'(recomb(out)), 64'(8'h22));
`endif

    // Back-pressure: fill, stall three cycles with new data offered, then release.
    cycle(1, 1, 0);
    repeat (3) begin
      cycle(1, 1, 0);
      check("bp_in_ready",  64'(in_ready),  64'(0));
      check("bp_rnd_ready", 64'(rnd_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    cycle(1, 1, 1);
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    check("bp_release_accepts",  64'(accepts),  64'(3));
    cycle(0, 0, 1);
    check("bp_second_valid", 64'(out_valid), 64'(1));
    cycle(0, 0, 1);

    // Randomness starvation.
    repeat (4) begin
      cycle(1, 0, 1);
      check("starve_rnd_ready", 64'(rnd_ready), 64'(1));
      check("starve_out_valid", 64'(out_valid), 64'(0));
    end
    cycle(1, 1, 1);
    check("starve_accept_valid0", 64'(out_valid), 64'(0));
    cycle(0, 0, 1);
    check("starve_then_valid", 64'(out_valid), 64'(1));
    cycle(0, 0, 1);

    // Reset while FULL and stalled.
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    check("pre_reset_full", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out",       64'(out),       64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));

    // Random regression.
    fires   = 0;
    accepts = 0;
    guard   = 0;
    while (accepts < N_RANDOM && guard < 20000) begin
      cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0);
      guard++;
    end
    check("rand_reached_count", 64'(accepts >= N_RANDOM), 64'(1));
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 10) begin
      cycle(0, 0, 1);
      guard++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("rnd_fire_count",    64'(fires),        64'(accepts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
